viterbi_dec: RTL and testbench
==============================

# viterbi_dec

Hard-decision Viterbi decoder for the rate-1/2 programmable-mask convolutional code produced by `conv_enc`. It sits directly downstream of the encoder, possibly across a channel model. It accepts one 2-bit code symbol per valid cycle and recovers the original data bit stream. Survivors are kept in a register-exchange memory of fixed decision depth.

## Interface
- `N`, 4: code window width. Equals the encoder `N`, which is mask width = constraint length. The decoder has 2^(N-1) states.
- `D`, 16: decision depth, the survivor path length in bits; must be ≥ 2.
- `MW`, 6: path-metric width in bits, unsigned and saturating.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 holds the block in its reset state.
- `load_mask`  in  2  bit0 loads `mask` into mask0; bit1 loads `mask` into mask1; 2'b11 loads both.
- `mask`  in  N  generator polynomial, MSB = tap on newest bit (leading 1 prepended, as for the encoder).
- `clear`  in  1  synchronous frame restart.
- `sym_valid`  in  1  `sym_in` is valid this cycle.
- `sym_in`  in  2  received symbol: bit1 is the mask1 parity, bit0 is the mask0 parity.
- `data_out`  out  1  decoded bit.
- `data_valid`  out  1  one-cycle qualifier for `data_out`.
- `best_metric`  out  MW  post-normalisation metric of the survivor state; 0 in normal operation, exposed for debug.

## Operation
- State s is N-1 bits: the last N-1 decoded bits, with s[N-2] the newest. The start state is 0, matching the encoder history reset to 0.
- Branch for input b from state s:
  - window w = {b, s}.
  - expected e1 = ^(mask1 & w), e0 = ^(mask0 & w).
  - next state s' = w[N-1:1].
  - branch metric = Hamming distance(sym_in, {e1, e0}), range 0..2.
- ACS for each s':
  - predecessors are {s'[N-3:0], x} for x = 0, 1.
  - candidate = pm[pred] + bm, saturating at 2^MW-1.
  - select the smaller candidate; on a tie choose x = 0.
- Path update: path[s'] = {path[pred][D-2:0], s'[N-2]}.
- Normalisation: after ACS, subtract the minimum new metric from every state metric. The best state therefore always holds 0.
- Best state = the lowest-index state with metric 0.
- Decision bit = the updated path[best][D-1].
- Fill counter: counts accepted symbols and saturates at D.
- Init condition (asserted by reset, `clear`, or any `load_mask` ≠ 0):
  - pm[0] = 0; every other pm = 2N.
  - all paths = 0; fill = 0.
  - `data_valid` = 0.
- Mask registers:
  - reset value is all-ones for both masks.
  - a load changes the masks only; the loaded value is used from the next accepted symbol onward.
- Priority: reset > `clear`/`load_mask` > `sym_valid`. A symbol presented in the same cycle as `clear` or `load_mask` is dropped.
- `sym_valid` = 0: all state and `data_out` hold; `data_valid` = 0.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `best_metric` = 0, masks all-ones, metrics and paths at the init condition.
- A symbol is accepted on the rising edge where reset = 1, `sym_valid` = 1, `clear` = 0, and `load_mask` = 0.
- `data_out`, `data_valid` and `best_metric` are registered and update on that same edge.
- After the edge accepting symbol k (k = 0 is the first after init):
  - `data_out` = decoded bit k-(D-1).
  - `data_valid` = 1 iff k ≥ D-1.
- The block accepts one symbol per cycle and applies no backpressure.
- At the end of a frame, the last D-1 bits are flushed by feeding tail symbols; the encoder supplies these when fed zeros.
- If reset is asserted mid-frame, outputs clear immediately (asynchronously), and the frame restarts at k = 0 after release.

## Test plan
- Error-free Viterbi demo:
  - Setup: N = 4, D = 16, load mask0 = 'o15, mask1 = 'o17.
  - Stimulus: sym_in stream 11,11,01,11,01,01,11 followed by 00s, i.e. data 1,0,1,1,0 then zeros.
  - Required: first `data_valid` on symbol 15; decoded stream 1,0,1,1,0,0,…; `best_metric` = 0 throughout.
- Single-error correction: same stream with symbol 2 corrupted from 01 to 00 → identical decoded output to the error-free case.
- All-zero input: 40 symbols of 00 → `data_out` = 0 on every valid pulse; exactly 25 `data_valid` pulses.
- Gapped `sym_valid`: insert 3 idle cycles between each symbol of the demo stream → identical decoded bits; `data_valid` pulses only on accept edges.
- `clear` / `load_mask` mid-frame, each exercised separately:
  - Stimulus: assert `clear` after symbol 20 with `sym_valid` = 1 in that cycle; in a separate run, reload mask0 = 'o15 after symbol 20.
  - Required: the symbol in the cycle of the `clear` or reload is dropped; the fill restarts, so the next `data_valid` occurs 16 accepted symbols later.
- Reset mid-frame: drop reset for 3 cycles between clock edges → `data_out`/`data_valid` go to 0 without a clock edge; re-running the demo stream reproduces the demo result.

Source files
------------

// File: rtl/viterbi_dec.sv
// Hard-decision Viterbi decoder for the rate-1/2 programmable-mask code produced by conv_enc.
// Register-exchange survivors of depth D; saturating path metrics re-normalised to a zero minimum.
module viterbi_dec #(
  parameter int N  = 4,
  parameter int D  = 16,
  parameter int MW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    load_mask,
  input  logic [N-1:0]  mask,
  input  logic          clear,
  input  logic          sym_valid,
  input  logic [1:0]    sym_in,
  output logic          data_out,
  output logic          data_valid,
  output logic [MW-1:0] best_metric
);
  localparam int unsigned   S        = 1 << (N-1);
  localparam int unsigned   FW       = $clog2(D+1);
  localparam logic [MW-1:0] PM_INIT  = MW'(2*N);
  localparam logic [FW-1:0] FILL_MAX = FW'(D);

  logic [N-1:0]  mask0_q, mask1_q;
  logic [MW-1:0] pm_q   [S];
  logic [MW-1:0] acs_pm [S];
  logic [MW-1:0] pm_d   [S];
  logic [D-1:0]  path_q [S];
  logic [D-1:0]  path_d [S];
  logic [FW-1:0] fill_q;
  logic [MW-1:0] min_pm;
  logic [N-2:0]  best_d;
  logic          data_out_q, data_valid_q;
  logic [MW-1:0] best_metric_q;
  logic          init;

  assign init = clear || (load_mask != 2'b00);

  function automatic logic [1:0] branch_metric(input logic [N-1:0] w,
                                               input logic [N-1:0] m0,
                                               input logic [N-1:0] m1,
                                               input logic [1:0]   sym);
    logic [1:0] diff;
    diff = sym ^ {^(m1 & w), ^(m0 & w)};
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] a, input logic [1:0] b);
    logic [MW:0] s;
    s = {1'b0, a} + {{(MW-1){1'b0}}, b};
    return s[MW] ? '1 : s[MW-1:0];
  endfunction

  // Add-compare-select: predecessors of ns differ only in their oldest bit x; ties keep x = 0.
  always_comb begin : acs
    logic [N-2:0]  ns, pred0, pred1;
    logic [MW-1:0] c0, c1;
    ns    = '0;
    pred0 = '0;
    pred1 = '0;
    c0    = '0;
    c1    = '0;
    for (int unsigned i = 0; i < S; i++) begin
      acs_pm[i] = '0;
      path_d[i] = '0;
    end
    for (int unsigned i = 0; i < S; i++) begin
      ns    = (N-1)'(i);
      pred0 = {ns[N-3:0], 1'b0};
      pred1 = {ns[N-3:0], 1'b1};
      c0 = sat_add(pm_q[pred0], branch_metric({ns[N-2], pred0}, mask0_q, mask1_q, sym_in));
      c1 = sat_add(pm_q[pred1], branch_metric({ns[N-2], pred1}, mask0_q, mask1_q, sym_in));
      if (c1 < c0) begin
        acs_pm[i] = c1;
        path_d[i] = {path_q[pred1][D-2:0], ns[N-2]};
      end else begin
        acs_pm[i] = c0;
        path_d[i] = {path_q[pred0][D-2:0], ns[N-2]};
      end
    end
  end

  always_comb begin : normalise
    logic found;
    found  = 1'b0;
    min_pm = '1;
    best_d = '0;
    for (int unsigned i = 0; i < S; i++) begin
      if (acs_pm[i] < min_pm) min_pm = acs_pm[i];
    end
    for (int unsigned i = 0; i < S; i++) begin
      pm_d[i] = acs_pm[i] - min_pm;
    end
    for (int unsigned i = 0; i < S; i++) begin
      if (!found && pm_d[i] == '0) begin
        best_d = (N-1)'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask0_q <= '1;
      mask1_q <= '1;
      for (int unsigned i = 0; i < S; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        path_q[i] <= '0;
      end
      fill_q        <= '0;
      data_out_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      best_metric_q <= '0;
    end else if (init) begin
      if (load_mask[0]) mask0_q <= mask;
      if (load_mask[1]) mask1_q <= mask;
      for (int unsigned i = 0; i < S; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        path_q[i] <= '0;
      end
      fill_q        <= '0;
      data_valid_q  <= 1'b0;
      best_metric_q <= '0;
    end else if (sym_valid) begin
      for (int unsigned i = 0; i < S; i++) begin
        pm_q[i]   <= pm_d[i];
        path_q[i] <= path_d[i];
      end
      if (fill_q != FILL_MAX) fill_q <= fill_q + FW'(1);
      data_out_q    <= path_d[best_d][D-1];
      data_valid_q  <= (fill_q >= FW'(D-1));
      best_metric_q <= pm_d[best_d];
    end else begin
      data_valid_q <= 1'b0;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign best_metric = best_metric_q;
endmodule

// File: tb/tb_viterbi_dec.sv
// Directed + randomised bench for viterbi_dec: expected bits are the encoded source data itself,
// delayed by the decision depth.
module tb_viterbi_dec;
  localparam int N  = 4;
  localparam int D  = 16;
  localparam int MW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    load_mask = 2'b00;
  logic [N-1:0]  mask = '0;
  logic          clear = 1'b0;
  logic          sym_valid = 1'b0;
  logic [1:0]    sym_in = 2'b00;
  logic          data_out;
  logic          data_valid;
  logic [MW-1:0] best_metric;

  viterbi_dec #(.N(N), .D(D), .MW(MW)) dut (
    .clk(clk), .reset(reset), .load_mask(load_mask), .mask(mask), .clear(clear),
    .sym_valid(sym_valid), .sym_in(sym_in), .data_out(data_out),
    .data_valid(data_valid), .best_metric(best_metric)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] m0 = '1;
  logic [N-1:0] m1 = '1;
  logic [N-2:0] hist = '0;
  bit           frame[$];
  int           k = 0;
  int           pulses = 0;
  bit           out_known = 1'b1;
  logic         exp_out = 1'b0;

  logic [1:0] demo_sym [7] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
  bit         demo_dat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic accept_raw(input logic [1:0] s, input bit b);
    frame.push_back(b);
    sym_valid = 1'b1;
    sym_in    = s;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    pulses += int'(data_valid === 1'b1);
    check("dvalid", 32'(data_valid), 32'(k >= D-1));
    if (k >= D-1) begin
      exp_out   = frame[k-(D-1)];
      out_known = 1'b1;
      check("dout", 32'(data_out), 32'(exp_out));
    end else begin
      out_known = 1'b0;
    end
    check("bmetric", 32'(best_metric), 32'(0));
    k++;
  endtask

  // Reference encoder: window {b, history}, MSB tap on the newest bit.
  task automatic accept_bit(input bit b, input logic [1:0] flip);
    logic [N-1:0] w;
    logic [1:0]   s;
    w    = {b, hist};
    s    = {^(m1 & w), ^(m0 & w)} ^ flip;
    hist = w[N-1:1];
    accept_raw(s, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_dv", 32'(data_valid), 32'(0));
      if (out_known) check("idle_hold", 32'(data_out), 32'(exp_out));
    end
  endtask

  task automatic restart(input logic c, input logic [1:0] lm, input logic [N-1:0] mk);
    clear     = c;
    load_mask = lm;
    mask      = mk;
    sym_valid = 1'b1;
    sym_in    = 2'($urandom);
    @(posedge clk); #1;
    clear     = 1'b0;
    load_mask = 2'b00;
    sym_valid = 1'b0;
    if (lm[0]) m0 = mk;
    if (lm[1]) m1 = mk;
    k = 0;
    frame.delete();
    hist = '0;
    out_known = 1'b0;
    check("init_dv", 32'(data_valid), 32'(0));
  endtask

  task automatic load_masks(input logic [N-1:0] a, input logic [N-1:0] b);
    restart(1'b0, 2'b01, a);
    restart(1'b0, 2'b10, b);
  endtask

  task automatic run_demo(input int nsym, input int err_idx, input int gap);
    for (int i = 0; i < nsym; i++) begin
      logic [1:0] s;
      bit         b;
      s = 2'b00;
      b = 1'b0;
      if (i < 7) s = demo_sym[i];
      if (i < 5) b = demo_dat[i];
      if (i == err_idx) s = s ^ 2'b01;
      accept_raw(s, b);
      if (gap > 0 && i != nsym-1) idle(gap);
    end
  endtask

  initial begin
    #12;
    check("rst_dout", 32'(data_out), 32'(0));
    check("rst_dv", 32'(data_valid), 32'(0));
    check("rst_bm", 32'(best_metric), 32'(0));
    #1 reset = 1'b1;

    load_masks(4'o15, 4'o17);
    run_demo(24, -1, 0);

    restart(1'b1, 2'b00, '0);
    run_demo(24, 2, 0);

    restart(1'b1, 2'b00, '0);
    pulses = 0;
    for (int i = 0; i < 40; i++) accept_raw(2'b00, 1'b0);
    check("zero_pulses", 32'(pulses), 32'(25));

    restart(1'b1, 2'b00, '0);
    run_demo(22, -1, 3);

    restart(1'b1, 2'b00, '0);
    for (int i = 0; i < 21; i++) accept_bit(1'($urandom), 2'b00);
    restart(1'b1, 2'b00, '0);
    for (int i = 0; i < 24; i++) accept_bit(1'($urandom), 2'b00);

    for (int i = 0; i < 21; i++) accept_bit(1'($urandom), 2'b00);
    restart(1'b0, 2'b01, 4'o15);
    for (int i = 0; i < 24; i++) accept_bit(1'($urandom), 2'b00);

    for (int f = 0; f < 4; f++) begin
      int unsigned p1, p2;
      load_masks((f % 2 == 0) ? 4'o15 : 4'o13, 4'o17);
      p1 = $urandom_range(20, 30);
      p2 = $urandom_range(55, 65);
      for (int unsigned i = 0; i < 80; i++)
        accept_bit(1'($urandom), (i == p1 || i == p2) ? 2'($urandom_range(1, 2)) : 2'b00);
    end

    // Asynchronous reset lands mid-frame while data_out is 1.
    load_masks(4'o15, 4'o17);
    run_demo(18, -1, 0);
    #2 reset = 1'b0;
    #1;
    check("arst_dout", 32'(data_out), 32'(0));
    check("arst_dv", 32'(data_valid), 32'(0));
    check("arst_bm", 32'(best_metric), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("arst_hold_dv", 32'(data_valid), 32'(0));
    end
    #3 reset = 1'b1;
    k = 0;
    frame.delete();
    hist = '0;
    m0 = '1;
    m1 = '1;
    out_known = 1'b1;
    exp_out = 1'b0;
    load_masks(4'o15, 4'o17);
    run_demo(24, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
